// File: rtl/pda_ctrl_pkg.sv
// Shared encodings for the PDA core multicycle controller: FSM states,
// opcode classes, extender / mux selects and ALU commands.
package pda_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  localparam logic [1:0] IMM13 = 2'b00;
  localparam logic [1:0] IMM17 = 2'b01;
  localparam logic [1:0] IMM26 = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;

  // States that hold a memory request open and are guarded by the wait timer.
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic logic [1:0] imm_sel(input op_t op);
    case (op)
      OP_MEM:  return IMM17;
      OP_BR:   return IMM26;
      default: return IMM13;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory request and flags the
// cycle in which the TIMEOUT-th such cycle occurs. TIMEOUT=0 disables it.
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A ready in the TIMEOUT-th cycle drops inc, so completion wins.
  assign expired = (TIMEOUT != 0) && inc && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the PDA core: sequences fetch/decode/execute/
// memory/writeback, selects the immediate format and guards memory waits.
module multicycle_ctrl
  import pda_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        cond_ok,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  imm_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  result_src,
  output logic        fault
);

  state_t     state_q, state_d;
  logic [1:0] imm_src_q, imm_src_d;
  op_t        op;
  logic       wait_clr, wait_inc, wait_expired;
  logic       unused_instr;

  assign op           = op_t'(instr[31:30]);
  assign unused_instr = ^instr[25:0];

  assign wait_inc = is_mem_wait(state_q) && !mem_ready;
  assign wait_clr = is_mem_wait(state_d) && (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      imm_src_q <= IMM13;
    end else begin
      state_q   <= state_d;
      imm_src_q <= imm_src_d;
    end
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    imm_src_d = imm_src_q;
    case (state_q)
      S_FETCH:
        if (mem_ready)         state_d = S_DECODE;
        else if (wait_expired) state_d = S_FAULT;
      S_DECODE: begin
        if (op != OP_ILL) imm_src_d = imm_sel(op);
        case (op)
          OP_DP:   state_d = S_EXEC;
          OP_MEM:  state_d = S_MEM_ADDR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FAULT;
        endcase
      end
      S_EXEC:     state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = instr[29] ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (mem_ready)         state_d = S_MEM_WB;
        else if (wait_expired) state_d = S_FAULT;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:
        if (mem_ready)         state_d = S_FETCH;
        else if (wait_expired) state_d = S_FAULT;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FAULT;
    endcase
  end

  // Strobes are masked by rst so an aborted instruction fires nothing.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    alu_ctrl   = ALU_ADD;
    result_src = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req   = !rst;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready && !rst;
        pc_write  = mem_ready && !rst;
      end
      S_EXEC: begin
        alu_src_b = instr[29] ? SRCB_IMM : SRCB_REG;
        alu_ctrl  = instr[28:26];
      end
      S_ALU_WB: begin
        reg_write  = !rst;
        result_src = RES_ALUOUT;
      end
      S_MEM_ADDR: alu_src_b = SRCB_IMM;
      S_MEM_RD: begin
        mem_req = !rst;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = !rst;
        result_src = RES_MEMDATA;
      end
      S_MEM_WR: begin
        mem_req = !rst;
        mem_we  = !rst;
        adr_src = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = cond_ok && !rst;
      end
      default: ;
    endcase
  end

  assign imm_src = imm_src_q;
  assign fault   = (state_q == S_FAULT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with TIMEOUT=4: walks load, DP, branch,
// illegal opcode, wait timeout and reset abort, checking every cycle's outputs.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        cond_ok;
  logic        mem_ready;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  imm_src, alu_src_b, result_src;
  logic        alu_src_a, fault;
  logic [2:0]  alu_ctrl;

  int n_asserts = 0;
  int n_fails   = 0;

  // {mem_req, mem_we, ir_write, pc_write, reg_write}
  localparam logic [4:0] ST_NONE  = 5'b00000;
  localparam logic [4:0] ST_FETCH = 5'b10110;
  localparam logic [4:0] ST_WAIT  = 5'b10000;
  localparam logic [4:0] ST_WR    = 5'b11000;
  localparam logic [4:0] ST_REGWR = 5'b00001;
  localparam logic [4:0] ST_PCWR  = 5'b00010;

  logic [4:0] strobes;
  assign strobes = {mem_req, mem_we, ir_write, pc_write, reg_write};

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(4), .CW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .cond_ok    (cond_ok),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .imm_src    (imm_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .result_src (result_src),
    .fault      (fault)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    instr     = 32'h0;
    cond_ok   = 1'b0;
    mem_ready = 1'b1;

    // Reset held for three cycles, strobes masked throughout.
    repeat (3) next_cycle();
    settle();
    check("rst_strobes", 32'(strobes), 32'(ST_NONE));
    rst = 1'b0;
    settle();
    check("fetch0_strobes", 32'(strobes), 32'(ST_FETCH));
    check("fetch0_adr_src", 32'(adr_src), 32'd0);
    check("fetch0_srca", 32'(alu_src_a), 32'd1);
    check("fetch0_srcb", 32'(alu_src_b), 32'b10);
    check("fetch0_alu", 32'(alu_ctrl), 32'b000);
    check("fetch0_imm", 32'(imm_src), 32'b00);
    check("fetch0_fault", 32'(fault), 32'd0);

    // Load with two wait states in MEM_RD.
    next_cycle(); instr = 32'h6000_0010; settle();
    check("ld_decode_strobes", 32'(strobes), 32'(ST_NONE));
    next_cycle(); settle();
    check("ld_addr_imm", 32'(imm_src), 32'b01);
    check("ld_addr_srcb", 32'(alu_src_b), 32'b01);
    check("ld_addr_alu", 32'(alu_ctrl), 32'b000);
    check("ld_addr_strobes", 32'(strobes), 32'(ST_NONE));
    next_cycle(); mem_ready = 1'b0; settle();
    check("ld_rd1_strobes", 32'(strobes), 32'(ST_WAIT));
    check("ld_rd1_adr", 32'(adr_src), 32'd1);
    next_cycle(); settle();
    check("ld_rd2_strobes", 32'(strobes), 32'(ST_WAIT));
    next_cycle(); mem_ready = 1'b1; settle();
    check("ld_rd3_strobes", 32'(strobes), 32'(ST_WAIT));
    next_cycle(); settle();
    check("ld_wb_strobes", 32'(strobes), 32'(ST_REGWR));
    check("ld_wb_res", 32'(result_src), 32'b01);
    next_cycle(); settle();
    check("ld_fetch_strobes", 32'(strobes), 32'(ST_FETCH));

    // DP with immediate, ALU cmd 001.
    next_cycle(); instr = 32'h2400_0005; settle();
    check("dp_decode_strobes", 32'(strobes), 32'(ST_NONE));
    check("dp_decode_imm_held", 32'(imm_src), 32'b01);
    next_cycle(); settle();
    check("dp_exec_imm", 32'(imm_src), 32'b00);
    check("dp_exec_srca", 32'(alu_src_a), 32'd0);
    check("dp_exec_srcb", 32'(alu_src_b), 32'b01);
    check("dp_exec_alu", 32'(alu_ctrl), 32'b001);
    check("dp_exec_strobes", 32'(strobes), 32'(ST_NONE));
    next_cycle(); settle();
    check("dp_wb_strobes", 32'(strobes), 32'(ST_REGWR));
    check("dp_wb_res", 32'(result_src), 32'b00);
    next_cycle(); settle();
    check("dp_fetch_strobes", 32'(strobes), 32'(ST_FETCH));

    // Branch not taken, then taken.
    next_cycle(); instr = 32'h8000_0100; cond_ok = 1'b0; settle();
    next_cycle(); settle();
    check("br0_imm", 32'(imm_src), 32'b10);
    check("br0_strobes", 32'(strobes), 32'(ST_NONE));
    check("br0_res", 32'(result_src), 32'b10);
    check("br0_srca", 32'(alu_src_a), 32'd1);
    check("br0_srcb", 32'(alu_src_b), 32'b01);
    next_cycle(); settle();
    check("br0_fetch_strobes", 32'(strobes), 32'(ST_FETCH));
    next_cycle(); cond_ok = 1'b1; settle();
    next_cycle(); settle();
    check("br1_strobes", 32'(strobes), 32'(ST_PCWR));
    check("br1_res", 32'(result_src), 32'b10);
    next_cycle(); cond_ok = 1'b0; settle();
    check("br1_fetch_strobes", 32'(strobes), 32'(ST_FETCH));

    // Illegal opcode: FAULT, imm_src keeps the branch format.
    next_cycle(); instr = 32'hC000_0000; settle();
    next_cycle(); settle();
    check("ill_fault", 32'(fault), 32'd1);
    check("ill_strobes", 32'(strobes), 32'(ST_NONE));
    check("ill_imm", 32'(imm_src), 32'b10);
    next_cycle(); settle();
    check("ill_fault_sticky", 32'(fault), 32'd1);
    rst = 1'b1; settle();
    check("ill_rst_strobes", 32'(strobes), 32'(ST_NONE));

    // Timeout: four consecutive not-ready cycles in FETCH.
    next_cycle(); rst = 1'b0; mem_ready = 1'b0; settle();
    check("to_rst_fault", 32'(fault), 32'd0);
    check("to_rst_imm", 32'(imm_src), 32'b00);
    check("to_w1_strobes", 32'(strobes), 32'(ST_WAIT));
    next_cycle(); settle();
    check("to_w2_strobes", 32'(strobes), 32'(ST_WAIT));
    next_cycle(); settle();
    check("to_w3_strobes", 32'(strobes), 32'(ST_WAIT));
    next_cycle(); settle();
    check("to_w4_strobes", 32'(strobes), 32'(ST_WAIT));
    check("to_w4_fault", 32'(fault), 32'd0);
    next_cycle(); mem_ready = 1'b1; settle();
    check("to_fault", 32'(fault), 32'd1);
    check("to_fault_strobes", 32'(strobes), 32'(ST_NONE));
    next_cycle(); settle();
    check("to_fault_sticky", 32'(fault), 32'd1);
    rst = 1'b1;

    // Ready on the 4th cycle wins over the timeout.
    next_cycle(); rst = 1'b0; mem_ready = 1'b0; settle();
    check("tw_rst_fault", 32'(fault), 32'd0);
    check("tw_w1_strobes", 32'(strobes), 32'(ST_WAIT));
    next_cycle(); settle();
    next_cycle(); settle();
    next_cycle(); mem_ready = 1'b1; settle();
    check("tw_ready4_strobes", 32'(strobes), 32'(ST_FETCH));
    check("tw_ready4_fault", 32'(fault), 32'd0);

    // Store aborted by rst while in MEM_WR.
    next_cycle(); instr = 32'h4000_0008; settle();
    check("tw_decode_fault", 32'(fault), 32'd0);
    next_cycle(); settle();
    check("st_addr_imm", 32'(imm_src), 32'b01);
    next_cycle(); mem_ready = 1'b0; settle();
    check("st_wr_strobes", 32'(strobes), 32'(ST_WR));
    check("st_wr_adr", 32'(adr_src), 32'd1);
    rst = 1'b1; settle();
    check("st_rst_we", 32'(mem_we), 32'd0);
    check("st_rst_req", 32'(mem_req), 32'd0);
    next_cycle(); rst = 1'b0; mem_ready = 1'b1; settle();
    check("st_rst_fetch_strobes", 32'(strobes), 32'(ST_FETCH));
    check("st_rst_fetch_srcb", 32'(alu_src_b), 32'b10);
    check("st_rst_fault", 32'(fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
